// File: rtl/processor_config.sv
// Word widths of the UART-attached processor that this host link talks to.
package processor_config;
  localparam int INP_WIDTH = 16;
  localparam int OUT_WIDTH = 16;
endpackage

// File: rtl/uart_pkg.sv
// Shared UART framing constants, FSM state encoding and bit-timing helper.
package uart_pkg;
  localparam int UART_WIDTH = 8;
  localparam int UART_PADS  = 2;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;

  // int'() of a real rounds to nearest, giving round(clk_freq / baud_rate).
  function automatic int clk_per_bit(real clk_freq, real baud_rate);
    return int'(clk_freq / baud_rate);
  endfunction
endpackage

// File: rtl/uart_host_link_rx.sv
// UART receive path: rxd synchronizer, 8N1 receive FSM and multi-byte word assembly.
module uart_host_link_rx
  import uart_pkg::*;
#(
  parameter int CLK_PER_BIT = 4,
  parameter int OUT_WIDTH   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rxd_i,
  output logic [OUT_WIDTH-1:0] m_tdata_o,
  output logic                 m_tvalid_o,
  input  logic                 m_tready_i,
  output logic                 busy_o,
  output logic                 error_o
);

  localparam int OUT_BYTES = (OUT_WIDTH + UART_WIDTH - 1) / UART_WIDTH;
  localparam int WORD_BITS = UART_WIDTH * OUT_BYTES;
  localparam int CNT_W     = $clog2(CLK_PER_BIT);
  localparam int BIT_W     = $clog2(UART_WIDTH);
  localparam int BYTE_W    = (OUT_BYTES > 1) ? $clog2(OUT_BYTES) : 1;
  localparam int HALF_BIT  = CLK_PER_BIT / 2;

  logic                  sync1_q, sync2_q;
  uart_state_t           state_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [BIT_W-1:0]      bit_q;
  logic [UART_WIDTH-1:0] shift_q;
  logic [BYTE_W-1:0]     byte_idx_q;
  logic [WORD_BITS-1:0]  buf_q;
  logic [WORD_BITS-1:0]  word_full;
  logic [OUT_WIDTH-1:0]  tdata_q;
  logic                  tvalid_q;
  logic                  error_q;
  logic                  rx_s;
  logic                  cnt_last;
  logic                  stop_ok;
  logic                  last_byte;

  assign rx_s      = sync2_q;
  assign cnt_last  = (cnt_q == CNT_W'(CLK_PER_BIT - 1));
  assign stop_ok   = (state_q == STOP) && cnt_last && rx_s;
  assign last_byte = (byte_idx_q == BYTE_W'(OUT_BYTES - 1));

  // The final byte goes straight from the shifter into the word, bypassing buf_q.
  always_comb begin
    word_full = buf_q;
    word_full[UART_WIDTH*(OUT_BYTES-1) +: UART_WIDTH] = shift_q;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      state_q    <= IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      byte_idx_q <= '0;
      tdata_q    <= '0;
      tvalid_q   <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      sync1_q <= rxd_i;
      sync2_q <= sync1_q;
      if (tvalid_q && m_tready_i) tvalid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (!rx_s) state_q <= START;
        end
        START: begin
          if (cnt_q == CNT_W'(HALF_BIT - 1)) begin
            cnt_q   <= '0;
            bit_q   <= '0;
            state_q <= rx_s ? IDLE : DATA;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DATA: begin
          if (cnt_last) begin
            cnt_q   <= '0;
            shift_q <= {rx_s, shift_q[UART_WIDTH-1:1]};
            bit_q   <= bit_q + 1'b1;
            if (bit_q == BIT_W'(UART_WIDTH - 1)) state_q <= STOP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        STOP: begin
          if (cnt_last) begin
            cnt_q   <= '0;
            state_q <= IDLE;
            if (!rx_s) begin
              error_q    <= 1'b1;
              byte_idx_q <= '0;
            end else if (last_byte) begin
              byte_idx_q <= '0;
              // A word completing while the previous one is still held is dropped.
              if (!tvalid_q || m_tready_i) begin
                tdata_q  <= OUT_WIDTH'(word_full);
                tvalid_q <= 1'b1;
              end else begin
                error_q <= 1'b1;
              end
            end else begin
              byte_idx_q <= byte_idx_q + 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // NOTE: byte storage has no reset; byte_idx_q restarts at 0, so stale bytes are always overwritten before use.
  always_ff @(posedge clk) begin
    if (stop_ok) buf_q[UART_WIDTH*byte_idx_q +: UART_WIDTH] <= shift_q;
  end

  assign m_tdata_o  = tdata_q;
  assign m_tvalid_o = tvalid_q;
  assign busy_o     = (state_q != IDLE);
  assign error_o    = error_q;

endmodule

// File: rtl/uart_host_link.sv
// Host-side UART link: serializes s_axis words to txd (LSB byte first) and
// reassembles rxd characters into m_axis words.
module uart_host_link
  import uart_pkg::*;
#(
  parameter real CLK_FREQ  = 100.0e6,
  parameter int  BAUD_RATE = 115_200,
  parameter int  INP_WIDTH = processor_config::INP_WIDTH,
  parameter int  OUT_WIDTH = processor_config::OUT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [INP_WIDTH-1:0] s_axis_tdata,
  input  logic                 s_axis_tvalid,
  output logic                 s_axis_tready,
  output logic [OUT_WIDTH-1:0] m_axis_tdata,
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready,
  input  logic                 rxd,
  output logic                 txd,
  output logic                 tx_busy,
  output logic                 rx_busy,
  output logic                 rx_error
);

  localparam int CLK_PER_BIT = clk_per_bit(CLK_FREQ, real'(BAUD_RATE));
  localparam int INP_BYTES   = (INP_WIDTH + UART_WIDTH - 1) / UART_WIDTH;
  localparam int TX_BITS     = UART_WIDTH * INP_BYTES;
  localparam int CNT_W       = $clog2(CLK_PER_BIT);
  localparam int BIT_W       = $clog2(UART_WIDTH);
  localparam int BYTE_W      = (INP_BYTES > 1) ? $clog2(INP_BYTES) : 1;

  if (CLK_PER_BIT < 4) begin : g_cpb_check
    $error("uart_host_link: CLK_FREQ/BAUD_RATE must give at least 4 clocks per bit");
  end

  uart_state_t           tx_state_q;
  logic [CNT_W-1:0]      tx_cnt_q;
  logic [BIT_W-1:0]      tx_bit_q;
  logic [BYTE_W-1:0]     tx_byte_q;
  logic [TX_BITS-1:0]    tx_word_q;
  logic                  txd_q;
  logic [UART_WIDTH-1:0] tx_cur_byte;
  logic                  tx_cnt_last;
  logic                  tx_accept;

  assign tx_cur_byte = tx_word_q[UART_WIDTH*tx_byte_q +: UART_WIDTH];
  assign tx_cnt_last = (tx_cnt_q == CNT_W'(CLK_PER_BIT - 1));
  assign tx_accept   = (tx_state_q == IDLE) && s_axis_tvalid;

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state_q <= IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_byte_q  <= '0;
      txd_q      <= 1'b1;
    end else begin
      case (tx_state_q)
        IDLE: begin
          if (s_axis_tvalid) begin
            tx_state_q <= START;
            tx_cnt_q   <= '0;
            tx_byte_q  <= '0;
            txd_q      <= 1'b0;
          end
        end
        START: begin
          if (tx_cnt_last) begin
            tx_state_q <= DATA;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            txd_q      <= tx_cur_byte[0];
          end else begin
            tx_cnt_q <= tx_cnt_q + 1'b1;
          end
        end
        DATA: begin
          if (tx_cnt_last) begin
            tx_cnt_q <= '0;
            if (tx_bit_q == BIT_W'(UART_WIDTH - 1)) begin
              tx_state_q <= STOP;
              txd_q      <= 1'b1;
            end else begin
              tx_bit_q <= tx_bit_q + 1'b1;
              txd_q    <= tx_cur_byte[tx_bit_q + BIT_W'(1)];
            end
          end else begin
            tx_cnt_q <= tx_cnt_q + 1'b1;
          end
        end
        STOP: begin
          if (tx_cnt_last) begin
            tx_cnt_q <= '0;
            // Bytes of one word go out back to back with no idle gap.
            if (tx_byte_q != BYTE_W'(INP_BYTES - 1)) begin
              tx_state_q <= START;
              tx_byte_q  <= tx_byte_q + 1'b1;
              txd_q      <= 1'b0;
            end else begin
              tx_state_q <= IDLE;
            end
          end else begin
            tx_cnt_q <= tx_cnt_q + 1'b1;
          end
        end
        default: tx_state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (tx_accept) tx_word_q <= TX_BITS'(s_axis_tdata);
  end

  assign s_axis_tready = (tx_state_q == IDLE);
  assign tx_busy       = (tx_state_q != IDLE);
  assign txd           = txd_q;

  uart_host_link_rx #(
    .CLK_PER_BIT (CLK_PER_BIT),
    .OUT_WIDTH   (OUT_WIDTH)
  ) u_rx (
    .clk        (clk),
    .rst        (rst),
    .rxd_i      (rxd),
    .m_tdata_o  (m_axis_tdata),
    .m_tvalid_o (m_axis_tvalid),
    .m_tready_i (m_axis_tready),
    .busy_o     (rx_busy),
    .error_o    (rx_error)
  );

endmodule

// File: tb/tb_uart_host_link.sv
// Directed bench for uart_host_link: 16-bit DUT driven from the bench, plus a
// 12-bit instance with txd looped back to rxd.
module tb_uart_host_link;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] s_tdata = '0;
  logic        s_tvalid = 1'b0;
  logic        s_tready;
  logic [15:0] m_tdata;
  logic        m_tvalid;
  logic        m_tready = 1'b0;
  logic        rxd = 1'b1;
  logic        txd;
  logic        tx_busy, rx_busy, rx_error;

  logic [11:0] lb_s_tdata = '0;
  logic        lb_s_tvalid = 1'b0;
  logic        lb_s_tready;
  logic [11:0] lb_m_tdata;
  logic        lb_m_tvalid;
  logic        lb_m_tready = 1'b0;
  logic        lb_line;
  logic        lb_tx_busy, lb_rx_busy, lb_rx_error;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_host_link #(
    .CLK_FREQ(400.0e3), .BAUD_RATE(100_000), .INP_WIDTH(16), .OUT_WIDTH(16)
  ) dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
    .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
    .rxd(rxd), .txd(txd), .tx_busy(tx_busy), .rx_busy(rx_busy), .rx_error(rx_error)
  );

  uart_host_link #(
    .CLK_FREQ(400.0e3), .BAUD_RATE(100_000), .INP_WIDTH(12), .OUT_WIDTH(12)
  ) dut_lb (
    .clk(clk), .rst(rst),
    .s_axis_tdata(lb_s_tdata), .s_axis_tvalid(lb_s_tvalid), .s_axis_tready(lb_s_tready),
    .m_axis_tdata(lb_m_tdata), .m_axis_tvalid(lb_m_tvalid), .m_axis_tready(lb_m_tready),
    .rxd(lb_line), .txd(lb_line), .tx_busy(lb_tx_busy), .rx_busy(lb_rx_busy),
    .rx_error(lb_rx_error)
  );

  task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected txd line, one entry per clock: two 8N1 characters of 4 clocks per bit.
  function automatic logic [79:0] frame2(input logic [15:0] w);
    logic [79:0] v;
    int slot, pos;
    for (int i = 0; i < 80; i++) begin
      slot = i / 40;
      pos  = (i % 40) / 4;
      if (pos == 0)      v[i] = 1'b0;
      else if (pos == 9) v[i] = 1'b1;
      else               v[i] = w[slot*8 + pos - 1];
    end
    return v;
  endfunction

  // Called right after tvalid is raised at a negedge; records 80 cycles of txd.
  task automatic capture_tx(input bit sel, output logic [79:0] v,
                            output int low_cnt, output int busy_cnt);
    low_cnt  = 0;
    busy_cnt = 0;
    v        = '0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      s_tvalid    = 1'b0;
      lb_s_tvalid = 1'b0;
      v[i]      = sel ? lb_line : txd;
      low_cnt  += int'(sel ? !lb_s_tready : !s_tready);
      busy_cnt += int'(sel ? lb_tx_busy : tx_busy);
    end
  endtask

  task automatic send_char(input logic [7:0] b, input logic stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rxd = f[i];
      repeat (4) @(negedge clk);
    end
  endtask

  task automatic wait_valid(input bit sel, input int max_cycles, input string tag);
    int n;
    n = 0;
    while (!(sel ? lb_m_tvalid : m_tvalid) && n < max_cycles) begin
      @(negedge clk);
      n++;
    end
    check(tag, sel ? lb_m_tvalid : m_tvalid, 1);
  endtask

  task automatic consume(input bit sel, input string tag);
    if (sel) lb_m_tready = 1'b1; else m_tready = 1'b1;
    @(negedge clk);
    lb_m_tready = 1'b0;
    m_tready    = 1'b0;
    check(tag, sel ? lb_m_tvalid : m_tvalid, 0);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [79:0] v;
    int lo, bz;
    logic [11:0] lb_words [3];
    lb_words[0] = 12'hABC;
    lb_words[1] = 12'h123;
    lb_words[2] = 12'hFFF;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_txd", txd, 1);
    check("reset_tready", s_tready, 1);
    check("reset_tvalid", m_tvalid, 0);
    check("reset_tdata", m_tdata, 0);
    check("reset_busy", {tx_busy, rx_busy}, 0);
    check("reset_rx_error", rx_error, 0);

    // TX word 0xA55A: 0x5A then 0xA5, 80 cycles busy.
    s_tdata  = 16'hA55A;
    s_tvalid = 1'b1;
    capture_tx(0, v, lo, bz);
    check("tx_frame", v, frame2(16'hA55A));
    check("tx_tready_low_cycles", lo, 80);
    check("tx_busy_cycles", bz, 80);
    @(negedge clk);
    check("tx_tready_after", s_tready, 1);
    check("tx_busy_after", tx_busy, 0);

    // Loopback at 12 bits: pad nibble on the wire must be zero.
    for (int k = 0; k < 3; k++) begin
      lb_s_tdata  = lb_words[k];
      lb_s_tvalid = 1'b1;
      capture_tx(1, v, lo, bz);
      check("lb_frame", v, frame2({4'h0, lb_words[k]}));
      check("lb_tready_low_cycles", lo, 80);
      wait_valid(1, 12, "lb_tvalid");
      check("lb_tdata", lb_m_tdata, lb_words[k]);
      consume(1, "lb_consume");
    end
    check("lb_rx_error", lb_rx_error, 0);

    // RX word: 0x34, 0x12 -> 0x1234.
    send_char(8'h34, 1'b1);
    send_char(8'h12, 1'b1);
    wait_valid(0, 3, "rx_tvalid");
    check("rx_tdata", m_tdata, 16'h1234);
    check("rx_error_clean", rx_error, 0);
    consume(0, "rx_consume");

    // Frame error then a good word.
    send_char(8'h55, 1'b0);
    rxd = 1'b1;
    repeat (8) @(negedge clk);
    check("fe_no_tvalid", m_tvalid, 0);
    check("fe_rx_error", rx_error, 1);
    send_char(8'hEF, 1'b1);
    send_char(8'hBE, 1'b1);
    wait_valid(0, 3, "fe_next_tvalid");
    check("fe_next_tdata", m_tdata, 16'hBEEF);
    check("fe_sticky", rx_error, 1);
    consume(0, "fe_consume");

    // Overrun: second word arrives while the first is still held.
    pulse_reset();
    check("ovr_error_cleared", rx_error, 0);
    send_char(8'h11, 1'b1);
    send_char(8'h11, 1'b1);
    send_char(8'h22, 1'b1);
    send_char(8'h22, 1'b1);
    repeat (4) @(negedge clk);
    check("ovr_tvalid_held", m_tvalid, 1);
    check("ovr_tdata_held", m_tdata, 16'h1111);
    check("ovr_rx_error", rx_error, 1);
    consume(0, "ovr_consume");
    repeat (50) @(negedge clk);
    check("ovr_no_second", m_tvalid, 0);

    // One-cycle glitch on rxd is ignored.
    pulse_reset();
    rxd = 1'b0;
    @(negedge clk);
    rxd = 1'b1;
    repeat (20) @(negedge clk);
    check("glitch_tvalid", m_tvalid, 0);
    check("glitch_rx_error", rx_error, 0);
    check("glitch_rx_busy", rx_busy, 0);

    // Reset in the middle of a TX data bit.
    s_tdata  = 16'h0000;
    s_tvalid = 1'b1;
    @(negedge clk);
    s_tvalid = 1'b0;
    repeat (8) @(negedge clk);
    check("midtx_txd_low", txd, 0);
    check("midtx_busy", tx_busy, 1);
    rst = 1'b1;
    @(negedge clk);
    check("midtx_rst_txd", txd, 1);
    check("midtx_rst_tready", s_tready, 1);
    check("midtx_rst_busy", tx_busy, 0);
    rst = 1'b0;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
